// File: rtl/sysbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sysbus_arbiter
// Purpose  : Two-client (fetch = client 0, data = client 1) round-robin
//            arbiter in front of a single split request/response sysbus.
//            A granted transaction owns the bus from grant until the end of
//            its response burst. Request address/tag are captured at grant
//            and held on the bus until the bus accepts them.
// Ports    : clk, reset (synchronous, active low)
//            cN_reqcyc/cN_req/cN_reqtag -> cN_reqack        client requests
//            cN_respcyc/cN_resp/cN_resptag <- cN_respack    client responses
//            bus_reqcyc/bus_req/bus_reqtag <- bus_reqack    bus request side
//            bus_respcyc/bus_resp/bus_resptag -> bus_respack bus response side
//            grant[1:0]   one-hot current owner, 0 when idle
//            timeout_err  one-cycle watchdog pulse (SYSBUS_ARB_TIMEOUT_EN only)
// Config   : define SYSBUS_ARB_TIMEOUT_EN to add the REQ/RESP watchdog of
//            TIMEOUT_CYCLES cycles and the timeout_err output.
// Revision : 1.0  initial release
// ============================================================================
module sysbus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    // client 0 (fetch)
    input  logic                      c0_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] c0_req,
    input  logic [BUS_TAG_WIDTH-1:0]  c0_reqtag,
    output logic                      c0_reqack,
    output logic                      c0_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] c0_resp,
    output logic [BUS_TAG_WIDTH-1:0]  c0_resptag,
    input  logic                      c0_respack,
    // client 1 (data)
    input  logic                      c1_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] c1_req,
    input  logic [BUS_TAG_WIDTH-1:0]  c1_reqtag,
    output logic                      c1_reqack,
    output logic                      c1_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] c1_resp,
    output logic [BUS_TAG_WIDTH-1:0]  c1_resptag,
    input  logic                      c1_respack,
    // sysbus master side
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_respack,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic [1:0]                grant
`ifdef SYSBUS_ARB_TIMEOUT_EN
    ,
    output logic                      timeout_err
`endif
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    // Elaboration guard: the watchdog compares against TIMEOUT_CYCLES-1.
    generate
        if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
            $error("sysbus_arbiter: TIMEOUT_CYCLES must be at least 2");
        end
    endgenerate

    logic [1:0]                r_state;
    logic [1:0]                r_grant;
    logic                      r_last;       // 1 = client 1 was granted last
    logic                      r_bus_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] r_bus_req;
    logic [BUS_TAG_WIDTH-1:0]  r_bus_reqtag;
    logic                      r_seen_beat;  // RESP has forwarded >= 1 beat

    logic [1:0]                w_state_nxt;
    logic [1:0]                w_grant_nxt;
    logic                      w_last_nxt;
    logic                      w_reqcyc_nxt;
    logic [BUS_DATA_WIDTH-1:0] w_req_nxt;
    logic [BUS_TAG_WIDTH-1:0]  w_tag_nxt;
    logic                      w_seen_nxt;
    logic                      w_pick;       // client chosen in IDLE

    logic                      w_in_req;
    logic                      w_in_resp;

`ifdef SYSBUS_ARB_TIMEOUT_EN
    localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TW-1:0] r_timer;
    logic [c_TW-1:0] w_timer_nxt;
    logic            r_timeout_err;
    logic            w_expired;
`endif

    // ------------------------------------------------------------------
    // Next-state / next-register logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_last_nxt   = r_last;
        w_reqcyc_nxt = r_bus_reqcyc;
        w_req_nxt    = r_bus_req;
        w_tag_nxt    = r_bus_reqtag;
        w_seen_nxt   = r_seen_beat;
        w_pick       = 1'b0;

        case (r_state)
            c_IDLE: begin
                if (c0_reqcyc || c1_reqcyc) begin
                    // On a tie the client that did not win last time goes;
                    // a lone requester always wins.
                    w_pick       = (c0_reqcyc && c1_reqcyc) ? ~r_last : c1_reqcyc;
                    w_grant_nxt  = w_pick ? 2'b10 : 2'b01;
                    w_last_nxt   = w_pick;
                    w_req_nxt    = w_pick ? c1_req    : c0_req;
                    w_tag_nxt    = w_pick ? c1_reqtag : c0_reqtag;
                    w_reqcyc_nxt = 1'b1;
                    w_seen_nxt   = 1'b0;
                    w_state_nxt  = c_REQ;
                end
            end
            c_REQ: begin
                // The request stays posted even if the owner drops reqcyc.
                if (bus_reqack) begin
                    w_reqcyc_nxt = 1'b0;
                    w_state_nxt  = c_RESP;
                end
            end
            c_RESP: begin
                if (bus_respcyc) begin
                    w_seen_nxt = 1'b1;
                end else if (r_seen_beat) begin
                    w_state_nxt = c_IDLE;
                    w_grant_nxt = 2'b00;
                end
            end
            default: begin
                w_state_nxt  = c_IDLE;
                w_grant_nxt  = 2'b00;
                w_reqcyc_nxt = 1'b0;
            end
        endcase

`ifdef SYSBUS_ARB_TIMEOUT_EN
        w_expired = (r_state != c_IDLE) && (r_timer == c_TW'(TIMEOUT_CYCLES - 1));
        if (w_expired) begin
            w_state_nxt  = c_IDLE;
            w_grant_nxt  = 2'b00;
            w_reqcyc_nxt = 1'b0;
        end

        // Cleared on entering REQ and on every response beat.
        if (r_state == c_IDLE) begin
            w_timer_nxt = '0;
        end else if (r_state == c_RESP && bus_respcyc) begin
            w_timer_nxt = '0;
        end else begin
            w_timer_nxt = r_timer + c_TW'(1);
        end
`endif
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= c_IDLE;
            r_grant      <= 2'b00;
            r_last       <= 1'b1;
            r_bus_reqcyc <= 1'b0;
            r_bus_req    <= '0;
            r_bus_reqtag <= '0;
            r_seen_beat  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last       <= w_last_nxt;
            r_bus_reqcyc <= w_reqcyc_nxt;
            r_bus_req    <= w_req_nxt;
            r_bus_reqtag <= w_tag_nxt;
            r_seen_beat  <= w_seen_nxt;
        end
    end

`ifdef SYSBUS_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_timer       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timer       <= w_timer_nxt;
            r_timeout_err <= w_expired;
        end
    end

    assign timeout_err = r_timeout_err;
`endif

    // ------------------------------------------------------------------
    // Outputs: handshakes are steered to the owner only while in the
    // matching phase, so stray bus strobes in other states are dropped.
    // ------------------------------------------------------------------
    assign w_in_req  = (r_state == c_REQ);
    assign w_in_resp = (r_state == c_RESP);

    assign grant      = r_grant;
    assign bus_reqcyc = r_bus_reqcyc;
    assign bus_req    = r_bus_req;
    assign bus_reqtag = r_bus_reqtag;

    assign c0_reqack  = w_in_req & r_grant[0] & bus_reqack;
    assign c1_reqack  = w_in_req & r_grant[1] & bus_reqack;

    assign c0_respcyc = w_in_resp & r_grant[0] & bus_respcyc;
    assign c1_respcyc = w_in_resp & r_grant[1] & bus_respcyc;
    assign c0_resp    = (w_in_resp & r_grant[0]) ? bus_resp    : '0;
    assign c1_resp    = (w_in_resp & r_grant[1]) ? bus_resp    : '0;
    assign c0_resptag = (w_in_resp & r_grant[0]) ? bus_resptag : '0;
    assign c1_resptag = (w_in_resp & r_grant[1]) ? bus_resptag : '0;

    assign bus_respack = w_in_resp &
                         ((r_grant[0] & c0_respack) | (r_grant[1] & c1_respack));

endmodule
`default_nettype wire

// File: doc/sysbus_arbiter.md
SYSBUS_ARBITER -- requirements
Module: sysbus_arbiter

Interface
REQ-001 Parameter BUS_DATA_WIDTH, 64, bus/request/response data width.
REQ-002 Parameter BUS_TAG_WIDTH, 13, bus tag width.
REQ-003 Parameter TIMEOUT_CYCLES, 1024, watchdog limit (used only under REQ-029).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-006 cN_reqcyc  input  1  client N (N=0 fetch, N=1 data) request valid; held with cN_req and cN_reqtag stable until cN_reqack.
REQ-007 cN_req  input  BUS_DATA_WIDTH  client N request address/data.
REQ-008 cN_reqtag  input  BUS_TAG_WIDTH  client N request tag.
REQ-009 cN_reqack  output  1  client N request accepted.
REQ-010 cN_respcyc  output  1  response beat valid to client N.
REQ-011 cN_resp, cN_resptag  output  BUS_DATA_WIDTH, BUS_TAG_WIDTH  response data/tag to client N.
REQ-012 cN_respack  input  1  client N response acknowledge.
REQ-013 bus_reqcyc, bus_req, bus_reqtag, bus_respack  output  1, BUS_DATA_WIDTH, BUS_TAG_WIDTH, 1  Sysbus master side.
REQ-014 bus_reqack, bus_respcyc, bus_resp, bus_resptag  input  1, 1, BUS_DATA_WIDTH, BUS_TAG_WIDTH  Sysbus slave side.
REQ-015 grant  output  2  one-hot current owner; 0 when idle.

Function
REQ-016 FSM states IDLE, REQ, RESP; one transaction owns the bus from grant until its response ends.
REQ-017 IDLE: if any cN_reqcyc, grant one client, capture its cN_req/cN_reqtag into bus_req/bus_reqtag, set bus_reqcyc=1, go REQ next cycle (1-cycle grant latency).
REQ-018 Arbitration round-robin: both requesting -> grant client not granted last; single requester always wins; last-grant pointer resets to 1 (client 0 wins first tie).
REQ-019 REQ: bus_reqcyc held 1; cN_reqack of owner = bus_reqack combinationally, other client's reqack 0; on bus_reqack, bus_reqcyc=0 next cycle, go RESP.
REQ-020 RESP: owner's cN_respcyc/cN_resp/cN_resptag = bus_respcyc/bus_resp/bus_resptag combinationally; bus_respack = owner's cN_respack; non-owner respcyc 0.
REQ-021 RESP ends on first cycle bus_respcyc=0 after at least one cycle with bus_respcyc=1; go IDLE, grant=0 next cycle.
REQ-022 bus_respcyc=1 in IDLE or REQ ignored; not forwarded; bus_respack 0.
REQ-023 cN_reqcyc dropped by owner before reqack in REQ: request not withdrawn; bus_reqcyc stays 1 until bus_reqack.
REQ-024 Request arriving from the non-owner during REQ/RESP waits; back-to-back grant possible in the IDLE cycle after RESP ends.
REQ-025 Bus outputs bus_req/bus_reqtag stable from grant until bus_reqack.

Reset
REQ-026 reset=0 at rising edge: state IDLE, grant=0, bus_reqcyc=0, bus_respack=0, bus_req=0, bus_reqtag=0, all cN_reqack/cN_respcyc=0, last-grant=1, timeout counter 0.
REQ-027 Reset mid-transaction aborts it without any further reqack/respcyc to either client.
REQ-028 First grant possible on the first edge with reset=1.

Configuration
REQ-029 Macro SYSBUS_ARB_TIMEOUT_EN defined: counter cleared on entering REQ and on each beat with bus_respcyc=1; counts in REQ/RESP; at TIMEOUT_CYCLES go IDLE, bus_reqcyc=0, bus_respack=0, and output timeout_err (1 bit) pulses 1 for one cycle.
REQ-030 Macro not defined: no counter, no timeout_err port; REQ/RESP wait indefinitely.

Verification
REQ-031 c0 alone requests addr 0x1000 -> grant=01 next cycle, bus_req=0x1000, bus_reqcyc high until bus_reqack, c0_reqack same cycle as bus_reqack.
REQ-032 c0, c1 request same cycle after reset -> c0 served first, c1 granted in IDLE cycle after c0's RESP ends; next tie goes to c0 again only after c1 won.
REQ-033 8-beat burst resp 0x11..0x88 to c1 with c1_respack=1 -> c1 receives all 8 beats in order, c0_respcyc stays 0, bus_respack mirrors c1_respack.
REQ-034 reset=0 asserted in RESP beat 3 -> all outputs zero next cycle, grant=0, no further beats forwarded.
REQ-035 With SYSBUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, bus_reqack never asserted -> timeout_err pulses once at 16 cycles after entering REQ, state IDLE, pending c1 then granted.
REQ-036 Spurious bus_respcyc=1 in IDLE -> no cN_respcyc, bus_respack 0, grant unchanged.
